spi_burst_reader: RTL and testbench



---
 rtl/spi_burst_pkg.sv | 16 +
 rtl/sync_fifo.sv | 56 +++++
 rtl/spi_burst_reader.sv | 146 ++++++++++++++
 tb/tb_spi_burst_reader.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_burst_pkg.sv
// Shared FSM type and Wishbone registered-feedback constants for the SPI burst reader
// and the SPI SRAM controller it feeds from.
package spi_burst_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StGap,
    StDrain
  } state_e;

  localparam logic [2:0] INCR_BURST   = 3'b010;
  localparam logic [2:0] END_OF_BURST = 3'b111;
  localparam logic [1:0] BTE_LINEAR   = 2'b00;

endpackage

// File: rtl/sync_fifo.sv
// Small first-word-fall-through FIFO with occupancy count and synchronous flush.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
      else if (!do_push && do_pop) count_q <= count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/spi_burst_reader.sv
// Wishbone incrementing-burst read master that streams bytes through a small FIFO,
// ending each burst early whenever the FIFO could otherwise overflow.
module spi_burst_reader
  import spi_burst_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 24,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic                  we_o,
  output logic [7:0]            dat_o,
  output logic [2:0]            cti_o,
  output logic [1:0]            bte_o,
  input  logic                  ack_i,
  input  logic                  err_i,
  input  logic [7:0]            dat_i,
  output logic [7:0]            data_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] LastFree = CntW'(DEPTH - 1);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic                  cyc_q, busy_q, done_q, err_q;

  logic [CntW-1:0] fifo_count;
  logic            fifo_full, fifo_empty;
  logic            push, pop, flush, bus_err, end_of_burst;

  assign bus_err = cyc_q && err_i;
  assign push    = cyc_q && ack_i && !err_i && !abort_i;
  assign pop     = valid_o && ready_i;
  assign flush   = abort_i || bus_err;

  // Ending when one slot is left guarantees room for the byte being acked now.
  assign end_of_burst = (remaining_q == LEN_WIDTH'(1)) || (fifo_count >= LastFree);

  assign cyc_o   = cyc_q;
  assign stb_o   = cyc_q;
  assign adr_o   = adr_q;
  assign we_o    = 1'b0;
  assign dat_o   = 8'h00;
  assign cti_o   = (cyc_q && end_of_burst) ? END_OF_BURST : INCR_BURST;
  assign bte_o   = BTE_LINEAR;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign valid_o = !fifo_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      adr_q       <= '0;
      remaining_q <= '0;
      cyc_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_i) begin
        state_q <= StIdle;
        cyc_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_i) begin
              if (len_i == '0) begin
                done_q <= 1'b1;
              end else begin
                adr_q       <= addr_i;
                remaining_q <= len_i;
                busy_q      <= 1'b1;
                err_q       <= 1'b0;
                state_q     <= StGap;
              end
            end
          end
          StGap: begin
            if (!fifo_full) begin
              cyc_q   <= 1'b1;
              state_q <= StReq;
            end
          end
          StReq: begin
            if (err_i) begin
              err_q   <= 1'b1;
              cyc_q   <= 1'b0;
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end else if (ack_i) begin
              adr_q       <= adr_q + ADDR_WIDTH'(1);
              remaining_q <= remaining_q - LEN_WIDTH'(1);
              if (end_of_burst) begin
                cyc_q   <= 1'b0;
                state_q <= (remaining_q == LEN_WIDTH'(1)) ? StDrain : StGap;
              end
            end
          end
          StDrain: begin
            if (pop && fifo_count == CntW'(1)) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .flush_i(flush),
    .push_i (push),
    .wdata_i(dat_i),
    .pop_i  (pop),
    .rdata_o(data_o),
    .count_o(fifo_count),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

endmodule

// File: tb/tb_spi_burst_reader.sv
// Directed bench for spi_burst_reader: Wishbone slave model, byte scoreboard, cti/address model.
module tb_spi_burst_reader;

  localparam int unsigned AW    = 24;
  localparam int unsigned LW    = 16;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic [LW-1:0] len_i = '0;
  logic          abort_i = 1'b0;
  logic          busy_o, done_o, err_o, cyc_o, stb_o, we_o;
  logic [AW-1:0] adr_o;
  logic [7:0]    dat_o, dat_i, data_o;
  logic [2:0]    cti_o;
  logic [1:0]    bte_o;
  logic          ack_i, err_i, valid_o;
  logic          ready_i = 1'b0;
  logic          slave_en = 1'b1;
  logic          err_inj = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(input string tag, input bit ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $error("FAIL %s", tag);
    end
  endfunction

  function automatic logic [7:0] mem_fn(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
  endfunction

  // Zero-wait-state slave: acks every cycle the strobe is up.
  assign ack_i = cyc_o && stb_o && slave_en && !err_inj;
  assign err_i = cyc_o && stb_o && err_inj;
  assign dat_i = mem_fn(adr_o);

  always #5 clk = ~clk;

  spi_burst_reader #(
    .ADDR_WIDTH(AW),
    .LEN_WIDTH (LW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .start_i(start_i),
    .addr_i (addr_i),
    .len_i  (len_i),
    .abort_i(abort_i),
    .busy_o (busy_o),
    .done_o (done_o),
    .err_o  (err_o),
    .cyc_o  (cyc_o),
    .stb_o  (stb_o),
    .adr_o  (adr_o),
    .we_o   (we_o),
    .dat_o  (dat_o),
    .cti_o  (cti_o),
    .bte_o  (bte_o),
    .ack_i  (ack_i),
    .err_i  (err_i),
    .dat_i  (dat_i),
    .data_o (data_o),
    .valid_o(valid_o),
    .ready_i(ready_i)
  );

  // Monitor / scoreboard, sampling on the falling edge.
  logic [7:0]    sb_q[$];
  logic [AW-1:0] exp_adr = '0;
  logic [AW-1:0] last_ack_adr = '0;
  int            rem = 0;
  int            bursts = 0;
  int            done_cnt = 0;
  int            pops = 0;
  bit            cyc_prev = 1'b0;
  bit            drop_pending = 1'b0;

  always @(negedge clk) begin
    logic [2:0] exp_cti;
    logic [7:0] exp_b;
    int         occ;
    if (!rst_n) begin
      sb_q.delete();
      cyc_prev     = 1'b0;
      drop_pending = 1'b0;
      rem          = 0;
    end else begin
      if (drop_pending) begin
        chk("cyc_drop", cyc_o === 1'b0);
        drop_pending = 1'b0;
      end
      if (cyc_o && !cyc_prev) bursts++;
      cyc_prev = cyc_o;
      if (done_o) done_cnt++;
      if (abort_i || (cyc_o && err_i)) begin
        sb_q.delete();
        if (cyc_o) drop_pending = 1'b1;
        rem = 0;
      end else begin
        if (start_i && !busy_o && len_i != '0) begin
          rem     = int'(len_i);
          exp_adr = addr_i;
        end
        occ = sb_q.size();
        if (valid_o && ready_i) begin
          if (sb_q.size() > 0) exp_b = sb_q.pop_front();
          else exp_b = 8'hxx;
          chk("stream_data", data_o === exp_b);
          pops++;
        end
        if (cyc_o && ack_i) begin
          exp_cti = (rem == 1 || occ + 1 >= DEPTH) ? 3'b111 : 3'b010;
          chk("ack_adr", adr_o === exp_adr);
          chk("ack_cti", cti_o === exp_cti);
          chk("ack_stb", stb_o === 1'b1);
          chk("no_overflow", occ < DEPTH);
          sb_q.push_back(mem_fn(exp_adr));
          if (exp_cti == 3'b111) drop_pending = 1'b1;
          last_ack_adr = exp_adr;
          exp_adr      = exp_adr + AW'(1);
          rem--;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l);
    addr_i  = a;
    len_i   = l;
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 300 && !done_o; i++) tick(1);
    chk(tag, done_o === 1'b1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, p0, b0, k;
    rst_n = 1'b0;
    #3;
    chk("rst_cyc", cyc_o === 1'b0);
    chk("rst_stb", stb_o === 1'b0);
    chk("rst_adr", adr_o === 24'h0);
    chk("rst_cti", cti_o === 3'b010);
    chk("rst_busy", busy_o === 1'b0);
    chk("rst_done", done_o === 1'b0);
    chk("rst_err", err_o === 1'b0);
    chk("rst_valid", valid_o === 1'b0);
    chk("rst_we", we_o === 1'b0);
    chk("rst_dat", dat_o === 8'h00);
    chk("rst_bte", bte_o === 2'b00);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // len=3, always ready: one burst 010,010,111
    ready_i = 1'b1;
    d0 = done_cnt; p0 = pops; b0 = bursts;
    start_cmd(24'h000010, 16'd3);
    chk("t1_busy", busy_o === 1'b1);
    wait_done("t1_done");
    tick(2);
    chk("t1_done_once", done_cnt == d0 + 1);
    chk("t1_pops", pops == p0 + 3);
    chk("t1_bursts", bursts == b0 + 1);
    chk("t1_busy_end", busy_o === 1'b0);
    chk("t1_sb_empty", sb_q.size() == 0);

    // len=10 with stalled consumer: first burst stops at FIFO full
    ready_i = 1'b0;
    d0 = done_cnt; p0 = pops; b0 = bursts;
    start_cmd(24'h000010, 16'd10);
    for (int i = 0; i < 100; i++) begin
      if (bursts == b0 + 1 && !cyc_o) break;
      tick(1);
    end
    tick(4);
    chk("t2_gap_cyc", cyc_o === 1'b0);
    chk("t2_one_burst", bursts == b0 + 1);
    chk("t2_valid", valid_o === 1'b1);
    chk("t2_no_pops", pops == p0);
    ready_i = 1'b1;
    for (int i = 0; i < 100 && !cyc_o; i++) tick(1);
    chk("t2_resume_cyc", cyc_o === 1'b1);
    chk("t2_resume_adr", adr_o === 24'h000014);
    wait_done("t2_done");
    tick(2);
    chk("t2_pops", pops == p0 + 10);
    chk("t2_done_once", done_cnt == d0 + 1);
    chk("t2_sb_empty", sb_q.size() == 0);

    // address wrap
    p0 = pops;
    start_cmd(24'hFFFFFE, 16'd3);
    wait_done("t3_done");
    tick(2);
    chk("t3_wrap_adr", last_ack_adr === 24'h000000);
    chk("t3_pops", pops == p0 + 3);

    // zero-length command
    d0 = done_cnt; b0 = bursts;
    start_cmd(24'h000200, 16'd0);
    chk("t4_done", done_o === 1'b1);
    chk("t4_busy", busy_o === 1'b0);
    tick(1);
    chk("t4_done_pulse", done_o === 1'b0);
    tick(4);
    chk("t4_no_bus", bursts == b0);
    chk("t4_done_cnt", done_cnt == d0 + 1);

    // abort after two acks
    ready_i = 1'b0;
    d0 = done_cnt;
    start_cmd(24'h000300, 16'd8);
    k = 0;
    for (int i = 0; i < 50; i++) begin
      if (ack_i) k++;
      if (k == 2) break;
      tick(1);
    end
    chk("t5_two_acks", k == 2);
    tick(1);
    abort_i = 1'b1;
    tick(1);
    abort_i = 1'b0;
    chk("t5_cyc", cyc_o === 1'b0);
    chk("t5_valid", valid_o === 1'b0);
    chk("t5_busy", busy_o === 1'b0);
    tick(4);
    chk("t5_no_done", done_cnt == d0);
    chk("t5_err", err_o === 1'b0);
    ready_i = 1'b1;
    p0 = pops;
    start_cmd(24'h000040, 16'd1);
    wait_done("t5_next_done");
    tick(2);
    chk("t5_next_pops", pops == p0 + 1);

    // bus error on the second byte
    ready_i = 1'b0;
    d0 = done_cnt;
    start_cmd(24'h000080, 16'd5);
    k = 0;
    for (int i = 0; i < 50; i++) begin
      if (ack_i) k++;
      if (k == 1) break;
      tick(1);
    end
    chk("t6_first_ack", k == 1);
    tick(1);
    err_inj = 1'b1;
    tick(1);
    err_inj = 1'b0;
    chk("t6_err", err_o === 1'b1);
    chk("t6_valid", valid_o === 1'b0);
    chk("t6_busy", busy_o === 1'b0);
    chk("t6_cyc", cyc_o === 1'b0);
    tick(3);
    chk("t6_no_done", done_cnt == d0);
    chk("t6_err_sticky", err_o === 1'b1);
    ready_i = 1'b1;
    start_cmd(24'h000090, 16'd2);
    chk("t6_err_clear", err_o === 1'b0);
    wait_done("t6_next_done");
    tick(2);

    // asynchronous reset mid-burst
    ready_i = 1'b0;
    start_cmd(24'h000100, 16'd8);
    for (int i = 0; i < 50 && !cyc_o; i++) tick(1);
    tick(1);
    rst_n = 1'b0;
    #1;
    chk("t7_cyc", cyc_o === 1'b0);
    chk("t7_busy", busy_o === 1'b0);
    chk("t7_valid", valid_o === 1'b0);
    chk("t7_adr", adr_o === 24'h0);
    chk("t7_cti", cti_o === 3'b010);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
